// File: rtl/cc_pkg.sv
// Shared definitions for the CC link receiver.
// FSM state encoding, default timing/frame parameters, address width.
package cc_pkg;

  localparam int CC_ADDR_W       = 12;
  localparam int BIT_CYCLES_DEF  = 51;
  localparam int HALF_BIT_DEF    = 25;
  localparam int SUBFRAME_DEF    = 2048;
  localparam int GAP_TIMEOUT_DEF = 1024;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_WRITE = 3'd4,
    S_BREAK = 3'd5
  } cc_state_e;

endpackage

// File: rtl/cc_rx_sync.sv
// Two-flop synchronizer on rx plus a third flop for falling-edge detect.
// Ports: clock, reset (sync, high), rx in; rs (synced rx), fall out.
module cc_rx_sync (
  input  logic clock,
  input  logic reset,
  input  logic rx,
  output logic rs,
  output logic fall
);

  logic s1_q, s2_q, s3_q;
  logic s1_d, s2_d, s3_d;

  always_comb begin
    s1_d = rx;
    s2_d = s1_q;
    s3_d = s2_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
      s3_q <= 1'b1;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
    end
  end

  assign rs   = s2_q;
  assign fall = s3_q & ~s2_q;

endmodule

// File: rtl/cc_receive.sv
// CC link serial byte receiver: writes bytes to frame RAM, flags frames.
// Ports: clock, reset, rx in; wraddress, wrdata, wren, frame_rdy,
// frame_err, byte_cnt out.
module cc_receive
  import cc_pkg::*;
#(
  parameter int SUBFRAME    = SUBFRAME_DEF,
  parameter int BIT_CYCLES  = BIT_CYCLES_DEF,
  parameter int HALF_BIT    = HALF_BIT_DEF,
  parameter int GAP_TIMEOUT = GAP_TIMEOUT_DEF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        rx,
  output logic [11:0] wraddress,
  output logic [7:0]  wrdata,
  output logic        wren,
  output logic        frame_rdy,
  output logic        frame_err,
  output logic [12:0] byte_cnt
);

  localparam int TW = $clog2(BIT_CYCLES + 1);
  localparam int GW = $clog2(GAP_TIMEOUT + 1);

  logic rs, fall;

  cc_rx_sync u_sync (
    .clock (clock),
    .reset (reset),
    .rx    (rx),
    .rs    (rs),
    .fall  (fall)
  );

  cc_state_e      state_q, state_d;
  logic [TW-1:0]  timer_q, timer_d;
  logic [2:0]     bit_q, bit_d;
  logic [7:0]     shift_q, shift_d;
  logic [CC_ADDR_W-1:0] addr_q, addr_d;
  logic [12:0]    cnt_q, cnt_d;
  logic [GW-1:0]  gap_q, gap_d;
  logic           rdy_q, rdy_d;
  logic           err_q, err_d;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    rdy_d   = 1'b0;
    err_d   = 1'b0;
    // count shows SUBFRAME for the rdy cycle, then the frame restarts
    if (rdy_q) begin
      cnt_d = '0;
      addr_d = '0;
    end
    unique case (state_q)
      S_IDLE: begin
        if (fall) begin
          timer_d = '0;
          gap_d   = '0;
          state_d = S_START;
        end else if (cnt_q != '0 && !rdy_q) begin
          if (gap_q == GW'(GAP_TIMEOUT - 1)) begin
            err_d  = 1'b1;
            cnt_d  = '0;
            addr_d = '0;
            gap_d  = '0;
          end else begin
            gap_d = gap_q + 1'b1;
          end
        end
      end
      S_START: begin
        if (timer_q == TW'(HALF_BIT - 1)) begin
          timer_d = '0;
          bit_d   = '0;
          state_d = rs ? S_IDLE : S_DATA;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_DATA: begin
        if (timer_q == TW'(BIT_CYCLES - 1)) begin
          timer_d = '0;
          shift_d[bit_q] = rs;
          bit_d = bit_q + 1'b1;
          if (bit_q == 3'd7) state_d = S_STOP;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_STOP: begin
        if (timer_q == TW'(BIT_CYCLES - 1)) begin
          timer_d = '0;
          if (rs) begin
            state_d = S_WRITE;
          end else begin
            err_d   = 1'b1;
            cnt_d   = '0;
            addr_d  = '0;
            state_d = S_BREAK;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_BREAK: begin
        // hold off until the line returns high
        if (rs) state_d = S_IDLE;
      end
      S_WRITE: begin
        addr_d  = addr_q + 1'b1;
        cnt_d   = cnt_q + 1'b1;
        gap_d   = '0;
        rdy_d   = (cnt_q + 13'd1) == 13'(SUBFRAME);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      addr_q  <= '0;
      cnt_q   <= '0;
      gap_q   <= '0;
      rdy_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      rdy_q   <= rdy_d;
      err_q   <= err_d;
    end
  end

  assign wren      = (state_q == S_WRITE);
  assign wrdata    = shift_q;
  assign wraddress = addr_q;
  assign byte_cnt  = cnt_q;
  assign frame_rdy = rdy_q;
  assign frame_err = err_q;

endmodule
